// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
package dmem_arb_pkg;

  // Arbiter FSM: IDLE accepts a request, ACCESS drives the memory for one cycle.
  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  // Port identifiers as stored in the last-grant and in-flight registers.
  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  // Low address bits that must be zero for a word-aligned access.
  localparam logic [1:0] MISALIGN_MASK = 2'b11;

  // Port id -> one-hot per-port vector.
  function automatic logic [1:0] port_onehot(input logic port);
    return (port == PORT1) ? 2'b10 : 2'b01;
  endfunction

  // One-hot grant -> port id (only meaningful when exactly one bit is set).
  function automatic logic port_of(input logic [1:0] onehot);
    return onehot[1] ? PORT1 : PORT0;
  endfunction

  // True when the byte address is not word aligned.
  function automatic logic is_misaligned(input logic [1:0] addr_lo);
    return (addr_lo & MISALIGN_MASK) != 2'b00;
  endfunction

endpackage

// File: rtl/dmem_arb_if.sv
// Requester-side and memory-side signals of the arbiter, bundled as one bus.
interface dmem_arb_if #(
  parameter int WIDTH = 32
) ();

  // Requester side, bit/element i belongs to port i.
  logic [1:0]            req;
  logic [1:0]            we;
  logic [1:0][WIDTH-1:0] addr;
  logic [1:0][WIDTH-1:0] wdata;
  logic [1:0]            gnt;
  logic [1:0]            rvalid;
  logic [WIDTH-1:0]      rdata;
  logic [1:0]            rerr;

  // Single-port data memory side; mem_rd is combinational from mem_addr.
  logic                  mem_we;
  logic [WIDTH-1:0]      mem_addr;
  logic [WIDTH-1:0]      mem_wd;
  logic [WIDTH-1:0]      mem_rd;

  // The arbiter itself.
  modport slave (
    input  req, we, addr, wdata, mem_rd,
    output gnt, rvalid, rdata, rerr, mem_we, mem_addr, mem_wd
  );

  // The environment: both requesters plus the memory.
  modport master (
    output req, we, addr, wdata, mem_rd,
    input  gnt, rvalid, rdata, rerr, mem_we, mem_addr, mem_wd
  );

endinterface

// File: rtl/dmem_arb_rr2.sv
// Two-way request selector: round-robin or fixed priority (port 0 first).
module arb_rr2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  input  logic       rr,
  output logic [1:0] grant
);

  // A lone requester always wins; a tie goes to the port not served last
  // in round-robin mode, otherwise to port 0.
  always_comb begin
    grant = 2'b00;
    unique case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (rr && (last == PORT0)) ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/dmem_arb.sv
// Two-port arbiter in front of a single-port data memory. One access is
// accepted in IDLE, driven to the memory in ACCESS, and completed with an
// rvalid pulse in the following cycle, which is IDLE again.
module dmem_arb
  import dmem_arb_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int RR    = 1
) (
  input  logic      clk,
  input  logic      reset,
  dmem_arb_if.slave bus
);

  localparam logic RR_EN = (RR != 0);

  // Control state
  state_e           state_q;
  logic             last_q;
  logic [1:0]       rvalid_q;
  logic [1:0]       rerr_q;
  logic [WIDTH-1:0] rdata_q;

  // Access captured at grant time; held stable for the whole ACCESS cycle
  logic             port_q;
  logic             we_q;
  logic             mis_q;
  logic [WIDTH-1:0] addr_q;
  logic [WIDTH-1:0] wdata_q;

  // Combinational selection and next-state values
  logic [1:0]       sel;
  logic [1:0]       gnt_d;
  logic             grant_fire;
  logic             grant_port;
  logic             grant_mis;
  logic [WIDTH-1:0] rdata_d;

  arb_rr2 u_sel (
    .req   (bus.req),
    .last  (last_q),
    .rr    (RR_EN),
    .grant (sel)
  );

  // Grants are only offered in IDLE and never while reset is held.
  always_comb begin
    gnt_d = 2'b00;
    if ((state_q == IDLE) && !reset) begin
      gnt_d = sel;
    end
  end

  assign grant_fire = |gnt_d;
  assign grant_port = port_of(gnt_d);
  assign grant_mis  = is_misaligned(bus.addr[grant_port][1:0]);

  // Completion data: stores and misaligned accesses return zero.
  always_comb begin
    rdata_d = '0;
    if (!we_q && !mis_q) begin
      rdata_d = bus.mem_rd;
    end
  end

  // FSM and response registers; a reset during ACCESS drops the completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      last_q   <= PORT1;
      rvalid_q <= 2'b00;
      rerr_q   <= 2'b00;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= 2'b00;
      rerr_q   <= 2'b00;
      unique case (state_q)
        IDLE: begin
          if (grant_fire) begin
            state_q <= ACCESS;
            last_q  <= grant_port;
          end
        end
        ACCESS: begin
          state_q  <= IDLE;
          rvalid_q <= port_onehot(port_q);
          rerr_q   <= mis_q ? port_onehot(port_q) : 2'b00;
          rdata_q  <= rdata_d;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Capture the granted port's request so later input changes cannot leak in.
  always_ff @(posedge clk) begin
    if (grant_fire) begin
      port_q  <= grant_port;
      we_q    <= bus.we[grant_port];
      mis_q   <= grant_mis;
      addr_q  <= bus.addr[grant_port];
      wdata_q <= bus.wdata[grant_port];
    end
  end

  // Memory port is driven only during ACCESS; a misaligned store never writes.
  always_comb begin
    bus.mem_we   = 1'b0;
    bus.mem_addr = '0;
    bus.mem_wd   = '0;
    if ((state_q == ACCESS) && !reset) begin
      bus.mem_we   = we_q && !mis_q;
      bus.mem_addr = addr_q;
      bus.mem_wd   = wdata_q;
    end
  end

  assign bus.gnt    = gnt_d;
  assign bus.rvalid = rvalid_q;
  assign bus.rerr   = rerr_q;
  assign bus.rdata  = rdata_q;

  // At most one port is granted in any cycle.
  a_gnt_onehot : assert property (@(posedge clk) disable iff (reset)
    $onehot0(bus.gnt));

  // No new grant while an access is on the memory port.
  a_no_gnt_in_access : assert property (@(posedge clk) disable iff (reset)
    (state_q == ACCESS) |-> (bus.gnt == 2'b00));

endmodule

// File: tb/tb_dmem_arb.sv
// Bench for dmem_arb: directed vector table, corner-case sequences and a
// randomized run against a transaction-level reference model.
module tb_dmem_arb;

  localparam int W = 32;

  logic clk = 1'b0;
  logic reset;
  bit   mem_init;

  always #5 clk = ~clk;

  dmem_arb_if #(.WIDTH(W)) a ();
  dmem_arb_if #(.WIDTH(W)) b ();

  dmem_arb #(.WIDTH(W), .RR(1)) u_rr (.clk(clk), .reset(reset), .bus(a.slave));
  dmem_arb #(.WIDTH(W), .RR(0)) u_fp (.clk(clk), .reset(reset), .bus(b.slave));

  // Data memory seen by the round-robin instance: 64 words, byte address [7:2].
  logic [W-1:0] mem [0:63];
  assign a.mem_rd = mem[a.mem_addr[7:2]];
  assign b.mem_rd = '0;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= (i == 25) ? 32'h19 : (32'h1000_0000 + i);
    end else if (a.mem_we) begin
      mem[a.mem_addr[7:2]] <= a.mem_wd;
    end
  end

  int errs   = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    a.req = '0; a.we = '0; a.addr = '0; a.wdata = '0;
    b.req = '0; b.we = '0; b.addr = '0; b.wdata = '0;
  endtask

  typedef struct {
    bit          port;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    bit          exp_err;
  } vec_t;

  vec_t vt [8];

  // One isolated transaction: grant at N, memory access at N+1, response at N+2.
  task automatic do_txn(input vec_t v, input int idx);
    logic [1:0] oh;
    bit         got;
    bit         exp_we;
    oh  = v.port ? 2'b10 : 2'b01;
    got = 0;
    idle_inputs();
    a.req[v.port]   = 1'b1;
    a.we[v.port]    = v.we;
    a.addr[v.port]  = v.addr;
    a.wdata[v.port] = v.wdata;
    for (int n = 0; n < 6; n++) begin
      samp();
      if (a.gnt != 2'b00) begin
        got = 1;
        break;
      end
      tick();
    end
    chk($sformatf("vec%0d_gnt", idx), a.gnt, oh);
    if (!got) begin
      idle_inputs();
      return;
    end
    tick();
    a.req = '0;
    a.addr[v.port] = 32'hFFFF_FFFC;
    samp();
    exp_we = v.we && (v.addr[1:0] == 2'b00);
    chk($sformatf("vec%0d_mem_we", idx), a.mem_we, exp_we);
    chk($sformatf("vec%0d_mem_addr", idx), a.mem_addr, v.addr);
    chk($sformatf("vec%0d_mem_wd", idx), a.mem_wd, v.wdata);
    chk($sformatf("vec%0d_gnt_access", idx), a.gnt, 2'b00);
    tick();
    samp();
    chk($sformatf("vec%0d_rvalid", idx), a.rvalid, oh);
    chk($sformatf("vec%0d_rerr", idx), a.rerr, v.exp_err ? oh : 2'b00);
    chk($sformatf("vec%0d_rdata", idx), a.rdata, v.exp_rdata);
    tick();
    samp();
    chk($sformatf("vec%0d_rvalid_end", idx), a.rvalid, 2'b00);
    chk($sformatf("vec%0d_rdata_hold", idx), a.rdata, v.exp_rdata);
    tick();
    idle_inputs();
  endtask

  // Reference-model state for the randomized phase.
  typedef struct {
    int          due;
    bit          port;
    bit          we;
    bit          mis;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
  } pend_t;

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errs);
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [1:0]  exp_a, exp_b, exp_rv;
    logic [31:0] ref_mem [0:63];
    pend_t       pq [$];
    pend_t       e;
    bit          act [2];
    bit          rwe [2];
    logic [31:0] raddr [2];
    logic [31:0] rwd [2];
    int          free_at;
    bit          mlast;
    bit          w;
    logic [1:0]  eg, erv, ere;
    logic        emwe;
    logic [31:0] ema, emwd, last_rd;
    int          idx, lo;

    vt[0] = '{0, 0, 32'h64, 32'h0,         32'h19,        0};
    vt[1] = '{1, 1, 32'h60, 32'hA5A5A5A5,  32'h0,         0};
    vt[2] = '{0, 0, 32'h60, 32'h0,         32'hA5A5A5A5,  0};
    vt[3] = '{0, 1, 32'h62, 32'h12345678,  32'h0,         1};
    vt[4] = '{1, 0, 32'h60, 32'h0,         32'hA5A5A5A5,  0};
    vt[5] = '{1, 0, 32'h61, 32'h0,         32'h0,         1};
    vt[6] = '{0, 1, 32'h70, 32'hDEADBEEF,  32'h0,         0};
    vt[7] = '{1, 0, 32'h70, 32'h0,         32'hDEADBEEF,  0};

    // Reset with both ports requesting: everything must stay quiet.
    reset    = 1'b1;
    mem_init = 1'b1;
    idle_inputs();
    a.req = 2'b11; a.we = 2'b11; a.addr[0] = 32'h40; a.addr[1] = 32'h44;
    a.wdata[0] = 32'h1; a.wdata[1] = 32'h2;
    b.req = 2'b11;
    tick();
    tick();
    samp();
    chk("rst_gnt", a.gnt, 2'b00);
    chk("rst_rvalid", a.rvalid, 2'b00);
    chk("rst_rerr", a.rerr, 2'b00);
    chk("rst_rdata", a.rdata, 32'h0);
    chk("rst_mem_we", a.mem_we, 1'b0);
    chk("rst_mem_addr", a.mem_addr, 32'h0);
    chk("rst_mem_wd", a.mem_wd, 32'h0);
    chk("rst_gnt_fp", b.gnt, 2'b00);
    tick();

    // Contention: both hold req for 8 cycles on both instances.
    reset    = 1'b0;
    mem_init = 1'b0;
    idle_inputs();
    a.req = 2'b11; a.addr[0] = 32'h10; a.addr[1] = 32'h14;
    b.req = 2'b11; b.addr[0] = 32'h10; b.addr[1] = 32'h14;
    for (int k = 0; k < 8; k++) begin
      samp();
      exp_a  = (k % 2 == 0) ? ((k % 4 == 0) ? 2'b01 : 2'b10) : 2'b00;
      exp_b  = (k % 2 == 0) ? 2'b01 : 2'b00;
      exp_rv = (k >= 2 && k % 2 == 0) ? ((k % 4 == 2) ? 2'b01 : 2'b10) : 2'b00;
      chk($sformatf("cont_rr_gnt%0d", k), a.gnt, exp_a);
      chk($sformatf("cont_fp_gnt%0d", k), b.gnt, exp_b);
      chk($sformatf("cont_rr_rvalid%0d", k), a.rvalid, exp_rv);
      tick();
    end
    idle_inputs();
    tick(); tick(); tick();

    // Directed vector table.
    foreach (vt[i]) do_txn(vt[i], i);
    chk("mem60_after_misaligned", mem[24], 32'hA5A5A5A5);

    // Reset in the middle of a store to 0x64.
    idle_inputs();
    a.req[0] = 1'b1; a.we[0] = 1'b1; a.addr[0] = 32'h64; a.wdata[0] = 32'h55;
    samp();
    chk("rstmid_gnt", a.gnt, 2'b01);
    tick();
    idle_inputs();
    reset = 1'b1;
    samp();
    chk("rstmid_mem_we_n1", a.mem_we, 1'b0);
    tick();
    reset = 1'b0;
    samp();
    chk("rstmid_rvalid_n2", a.rvalid, 2'b00);
    chk("rstmid_mem_we_n2", a.mem_we, 1'b0);
    chk("rstmid_rdata_n2", a.rdata, 32'h0);
    tick();
    samp();
    chk("rstmid_rvalid_n3", a.rvalid, 2'b00);
    chk("rstmid_mem64", mem[25], 32'h19);
    tick();
    a.req = 2'b11; a.addr[0] = 32'h64; a.addr[1] = 32'h60;
    samp();
    chk("rstmid_tie_gnt", a.gnt, 2'b01);
    tick();
    idle_inputs();
    tick(); tick(); tick();

    // Port 1 requests for one cycle while port 0 is in flight, then withdraws.
    a.req[0] = 1'b1; a.addr[0] = 32'h64;
    samp();
    chk("wd_gnt0", a.gnt, 2'b01);
    tick();
    idle_inputs();
    a.req[1] = 1'b1; a.addr[1] = 32'h60;
    samp();
    chk("wd_gnt_access", a.gnt, 2'b00);
    tick();
    idle_inputs();
    samp();
    chk("wd_gnt_n2", a.gnt, 2'b00);
    chk("wd_rvalid_n2", a.rvalid, 2'b01);
    chk("wd_rdata_n2", a.rdata, 32'h19);
    tick();
    samp();
    chk("wd_gnt_n3", a.gnt, 2'b00);
    chk("wd_rvalid_n3", a.rvalid, 2'b00);
    tick();

    // Randomized phase against a transaction-level model.
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    for (int i = 0; i < 64; i++) ref_mem[i] = mem[i];
    free_at = 0;
    mlast   = 1'b1;
    last_rd = 32'h0;
    for (int p = 0; p < 2; p++) begin
      act[p] = 0; rwe[p] = 0; raddr[p] = '0; rwd[p] = '0;
    end
    for (int cyc = 0; cyc < 2000; cyc++) begin
      for (int p = 0; p < 2; p++) begin
        a.req[p] = act[p]; a.we[p] = rwe[p]; a.addr[p] = raddr[p]; a.wdata[p] = rwd[p];
      end
      samp();
      erv = 2'b00; ere = 2'b00; emwe = 1'b0; ema = '0; emwd = '0; eg = 2'b00;
      if (pq.size() > 0 && pq[0].due == cyc) begin
        e   = pq.pop_front();
        erv = e.port ? 2'b10 : 2'b01;
        ere = e.mis ? erv : 2'b00;
        chk("rnd_rdata", a.rdata, e.rd);
        last_rd = e.rd;
      end else begin
        chk("rnd_rdata_hold", a.rdata, last_rd);
      end
      if (pq.size() > 0 && pq[0].due == cyc + 1) begin
        emwe = pq[0].we && !pq[0].mis;
        ema  = pq[0].addr;
        emwd = pq[0].wd;
      end
      if (cyc >= free_at && (act[0] || act[1])) begin
        w      = (act[0] && act[1]) ? !mlast : act[1];
        e.due  = cyc + 2;
        e.port = w;
        e.we   = rwe[w];
        e.mis  = (raddr[w][1:0] != 2'b00);
        e.addr = raddr[w];
        e.wd   = rwd[w];
        e.rd   = (e.mis || e.we) ? 32'h0 : ref_mem[raddr[w][7:2]];
        if (e.we && !e.mis) ref_mem[raddr[w][7:2]] = rwd[w];
        pq.push_back(e);
        free_at = cyc + 2;
        mlast   = w;
        eg      = w ? 2'b10 : 2'b01;
      end
      chk("rnd_gnt", a.gnt, eg);
      chk("rnd_rvalid", a.rvalid, erv);
      chk("rnd_rerr", a.rerr, ere);
      chk("rnd_mem_we", a.mem_we, emwe);
      chk("rnd_mem_addr", a.mem_addr, ema);
      chk("rnd_mem_wd", a.mem_wd, emwd);
      tick();
      for (int p = 0; p < 2; p++) begin
        if (eg[p]) begin
          act[p] = 0;
        end else if (act[p] && $urandom_range(0, 15) == 0) begin
          act[p] = 0;
        end else if (!act[p] && $urandom_range(0, 1) == 1) begin
          act[p]   = 1;
          rwe[p]   = $urandom_range(0, 1);
          idx      = $urandom_range(0, 63);
          lo       = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0;
          raddr[p] = {24'h0, idx[5:0], lo[1:0]};
          rwd[p]   = $urandom;
        end
      end
    end
    idle_inputs();
    tick(); tick(); tick();
    for (int i = 0; i < 64; i++) chk($sformatf("rnd_mem%0d", i), mem[i], ref_mem[i]);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/dmem_arb.md
DMEM_ARB -- requirements
Module: dmem_arb

Interface
REQ-001 Parameter WIDTH, default 32: data and address width of every port.
REQ-002 Parameter RR, default 1: 1 selects round-robin arbitration, 0 selects fixed priority with port 0 highest.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req  input  2  request per port; bit i belongs to port i.
REQ-006 we  input  2  per-port write enable (1 = store, 0 = load).
REQ-007 addr  input  2xWIDTH  per-port byte address.
REQ-008 wdata  input  2xWIDTH  per-port store data.
REQ-009 gnt  output  2  per-port one-cycle accept pulse.
REQ-010 rvalid  output  2  per-port one-cycle completion pulse.
REQ-011 rdata  output  WIDTH  load data; shared by both ports, qualified by rvalid.
REQ-012 rerr  output  2  per-port misalignment error, qualified by rvalid.
REQ-013 mem_we  output  1  write strobe to the single-port data memory.
REQ-014 mem_addr  output  WIDTH  address to the data memory.
REQ-015 mem_wd  output  WIDTH  write data to the data memory.
REQ-016 mem_rd  input  WIDTH  combinational read data from the data memory.

Function
REQ-017 The FSM SHALL have two states: IDLE and ACCESS.
REQ-018 In IDLE, gnt[i] SHALL be combinationally 1 only for the selected requesting port; at most one gnt bit is set in any cycle.
REQ-019 Selection with RR=1: if both ports request, grant the port not granted last; if only one requests, grant that port.
REQ-020 Selection with RR=0: port 0 SHALL always win when both ports request.
REQ-021 On a grant, the port's we, addr and wdata SHALL be latched, the granted port id recorded, and the FSM SHALL move to ACCESS.
REQ-022 In ACCESS, mem_addr and mem_wd SHALL come from the latched values; mem_we SHALL equal the latched we for exactly that one cycle.
REQ-023 In ACCESS, no gnt SHALL be issued.
REQ-024 The FSM SHALL return from ACCESS to IDLE unconditionally.
REQ-025 Outside ACCESS, mem_we SHALL be 0, and mem_addr and mem_wd SHALL be 0.
REQ-026 Latency: for a grant in cycle N, rvalid[i] SHALL pulse in cycle N+2.
REQ-027 For loads, rdata SHALL equal mem_rd as sampled at the end of cycle N+1.
REQ-028 For stores, rvalid SHALL also pulse (write acknowledge), with rdata = 0.
REQ-029 The cycle carrying rvalid is IDLE, so a new grant MAY occur in that same cycle; maximum throughput is one access per 2 cycles.
REQ-030 If addr[1:0] != 0 at grant: the access SHALL proceed with mem_we forced to 0, rerr[i] SHALL be 1 with rvalid[i], and rdata SHALL be 0.
REQ-031 In all other cases, rerr SHALL be 0.
REQ-032 A requester SHALL hold req, we, addr and wdata stable until gnt; dropping req before gnt SHALL withdraw the request with no side effect.
REQ-033 Inputs changing during ACCESS SHALL NOT affect the access in flight.
REQ-034 rdata SHALL hold its value between rvalid pulses.

Reset
REQ-035 While reset=1: FSM SHALL be IDLE; gnt, rvalid, rerr, rdata, mem_we, mem_addr and mem_wd SHALL be 0; last-grant SHALL be port 1, so port 0 wins the first tie.
REQ-036 Reset asserted during ACCESS SHALL abort the access: mem_we SHALL be 0 from the next edge, and no rvalid SHALL be issued for that access.

Structure
REQ-037 Package dmem_arb_pkg SHALL hold the state enum (IDLE, ACCESS), the port-id constants PORT0/PORT1, and the misalignment-mask constant.
REQ-038 Sub-module arb_rr2 SHALL implement the two-way select: inputs req[1:0], last, rr; output one-hot grant; purely combinational.

Verification
REQ-039 Single load: port 0 load, addr=0x64, memory word 0x19 -> gnt[0] at N, mem_we=0 at N+1, rvalid[0] at N+2 with rdata=0x19 and rerr=0.
REQ-040 Single store: port 1 store, addr=0x60, wdata=0xA5A5A5A5 -> mem_we=1 with mem_addr=0x60 at N+1; rvalid[1] at N+2 with rdata=0; a following load of 0x60 returns 0xA5A5A5A5.
REQ-041 Contention: both ports hold req for 8 cycles with RR=1 -> grants strictly alternate 0,1,0,1 every 2 cycles; with RR=0 -> all grants go to port 0.
REQ-042 Misaligned: port 0 store, addr=0x62 -> mem_we stays 0, rvalid[0] and rerr[0] pulse at N+2, and the memory word at 0x60 is unchanged.
REQ-043 Reset mid-access: assert reset during the ACCESS of a store to 0x64 -> no mem_we after the reset edge, no rvalid, and the first grant after reset goes to port 0 under a tie.
REQ-044 Withdrawn request: port 1 raises req for one cycle while port 0 is being served, then drops it -> gnt[1] never asserts and no rvalid[1] is issued.
